// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, start-edge detect, mid-bit sampling, one-cycle done_rx strobe.
// Optional `UART_RX_MAJORITY_EN: 2-of-3 majority vote over three consecutive samples at every sample point.
module uart_rx #(
  parameter int unsigned clk_freq  = 50000000,
  parameter int unsigned baud_rate = 19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       done_rx,
  output logic       rx_active,
  output logic       frame_err
);

  localparam int unsigned clock_divide = clk_freq / baud_rate;
  localparam int unsigned half_divide  = clock_divide / 2;
  localparam int unsigned cnt_w        = 12;
  localparam logic [cnt_w-1:0] full_last = cnt_w'(clock_divide - 1);
  localparam logic [cnt_w-1:0] half_last = cnt_w'(half_divide - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [cnt_w-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       data_nxt;
  logic             done_nxt, ferr_nxt, active_nxt;

  logic rx_meta, rx_s, rx_prev;
  logic fall_c;
  logic [cnt_w-1:0] last_c;
  logic bit_c;

  // Synchroniser and edge history; idle line is high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall_c = rx_prev & ~rx_s;
  assign last_c = (state == START) ? half_last : full_last;

`ifdef UART_RX_MAJORITY_EN
  logic maj_a, maj_b;

  // First two votes are captured on the two cycles before the sample point
  always_ff @(posedge clk) begin
    if (rst) begin
      maj_a <= 1'b1;
      maj_b <= 1'b1;
    end else begin
      if (cnt == last_c - cnt_w'(2)) maj_a <= rx_s;
      if (cnt == last_c - cnt_w'(1)) maj_b <= rx_s;
    end
  end

  assign bit_c = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
`else
  assign bit_c = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= '0;
      done_rx   <= 1'b0;
      frame_err <= 1'b0;
      rx_active <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shift     <= shift_nxt;
      rx_data   <= data_nxt;
      done_rx   <= done_nxt;
      frame_err <= ferr_nxt;
      rx_active <= active_nxt;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    data_nxt  = rx_data;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (fall_c) state_nxt = START;
      end
      START: begin
        if (cnt == half_last) begin
          cnt_nxt   = '0;
          state_nxt = bit_c ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + cnt_w'(1);
        end
      end
      DATA: begin
        if (cnt == full_last) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = bit_c;
          if (idx == 3'd7) begin
            idx_nxt   = '0;
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + cnt_w'(1);
        end
      end
      STOP: begin
        if (cnt == full_last) begin
          cnt_nxt = '0;
          if (bit_c) begin
            state_nxt = DONE;
            data_nxt  = shift;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + cnt_w'(1);
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    active_nxt = (state_nxt == DATA);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner sequences and random frames vs a byte-level model.
module tb_uart_rx;

  localparam int unsigned BIT_CLK = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       done_rx, rx_active, frame_err;

  int total = 0;
  int bad   = 0;

  int done_cnt = 0, ferr_cnt = 0, act_cnt = 0;
  logic done_prev = 1'b0;
  logic [7:0] hist[$];

  uart_rx #(.clk_freq(1000000), .baud_rate(100000)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_data(rx_data), .done_rx(done_rx), .rx_active(rx_active), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Output monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (done_rx) begin
      done_cnt++;
      hist.push_back(rx_data);
      check("done_rx_one_cycle", int'(done_prev), 0);
    end
    if (frame_err) ferr_cnt++;
    if (rx_active) act_cnt++;
    done_prev = done_rx;
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(1'b1, n);
  endtask

  // Line stays at the stop level afterwards; caller decides what follows
  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(d[i], BIT_CLK);
    drive(stop, BIT_CLK);
  endtask

  // Each bit carries a one-clock inverted pulse across its mid-sample window
  task automatic send_frame_glitch(input logic [7:0] d);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(bits[i], 5);
      drive(~bits[i], 1);
      drive(bits[i], 4);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_rx_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0, f0, a0;
    logic [7:0] model_q[$];
    logic [7:0] last_good;
    int model_ferr;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b0, 0, 1, 8'h00};

    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_done_rx", int'(done_rx), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_rx_active", int'(rx_active), 0);
    rst = 1'b0;
    idle(5);

    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      idle(8);
      check($sformatf("vec%0d_done", v), done_cnt - d0, vecs[v].exp_done);
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_rx_data", v), int'(rx_data), int'(vecs[v].exp_rx_data));
    end

    // Back-to-back frames with no idle gap
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(8);
    check("b2b_done", done_cnt - d0, 2);
    check("b2b_ferr", ferr_cnt - f0, 0);
    if (hist.size() >= 2) begin
      check("b2b_first", int'(hist[hist.size()-2]), 8'h00);
      check("b2b_second", int'(hist[hist.size()-1]), 8'hFF);
    end else begin
      check("b2b_hist_size", hist.size(), 2);
    end

    // Short low pulse is rejected as a false start
    d0 = done_cnt; f0 = ferr_cnt; a0 = act_cnt;
    drive(1'b0, 3);
    idle(30);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_active", act_cnt - a0, 0);

    // Framing error, then a long low line must not start a frame
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    a0 = act_cnt;
    drive(1'b0, 50);
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_no_done", done_cnt - d0, 0);
    check("ferr_low_no_active", act_cnt - a0, 0);
    check("ferr_rx_data_kept", int'(rx_data), 8'hFF);
    idle(4);
    d0 = done_cnt;
    send_frame(8'h96, 1'b1);
    idle(8);
    check("after_ferr_done", done_cnt - d0, 1);
    check("after_ferr_rx_data", int'(rx_data), 8'h96);

    // Reset in the middle of data bit 4
    d0 = done_cnt; f0 = ferr_cnt;
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive(1'b1, BIT_CLK);
    drive(1'b1, 5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rx_data", int'(rx_data), 0);
    check("midrst_done_rx", int'(done_rx), 0);
    check("midrst_frame_err", int'(frame_err), 0);
    check("midrst_rx_active", int'(rx_active), 0);
    rst = 1'b0;
    idle(120);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_ferr", ferr_cnt - f0, 0);
    d0 = done_cnt;
    send_frame(8'h5A, 1'b1);
    idle(8);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_rx_data", int'(rx_data), 8'h5A);

    // Transmitter-style frame of 0x81
    d0 = done_cnt;
`ifdef UART_RX_MAJORITY_EN
    send_frame_glitch(8'h81);
`else
    send_frame(8'h81, 1'b1);
`endif
    idle(8);
    check("loop_done", done_cnt - d0, 1);
    check("loop_rx_data", int'(rx_data), 8'h81);

    // Random frames against a byte-level model
    d0 = done_cnt; f0 = ferr_cnt;
    hist.delete();
    last_good  = 8'h81;
    model_ferr = 0;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic stop;
      int gap;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
      send_frame(d, stop);
      if (stop) begin
        model_q.push_back(d);
        last_good = d;
      end else begin
        model_ferr++;
      end
      if (gap > 0) idle(gap);
      else rx = 1'b1;
    end
    idle(12);
    check("rand_done_count", done_cnt - d0, model_q.size());
    check("rand_ferr_count", ferr_cnt - f0, model_ferr);
    for (int i = 0; i < model_q.size(); i++) begin
      if (i < hist.size()) check($sformatf("rand_byte%0d", i), int'(hist[i]), int'(model_q[i]));
    end
    check("rand_final_rx_data", int'(rx_data), int'(last_good));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
